tick_countdown_timer: RTL
=========================

Name: tick_countdown_timer

Overview:
Consumer end of the divided slow clock. Samples the 1 Hz square wave in the 50 MHz domain and turns each rising edge into a one-cycle tick enable. Uses those ticks to run a loadable, pausable countdown, used for parking-session and gate-open timeouts. Flags expiry with a sticky level and a single-cycle pulse.

Parameters:
TIMER_W, 16, width of countdown value in seconds (ticks)
SYNC_STAGES, 2, synchronizer flop depth for clk_1Hz (min 2)

Ports:
clk_50MHz  input  1  system clock
reset_n  input  1  asynchronous active-low reset
clk_1Hz  input  1  slow square wave from the clock divider; treated as asynchronous
load  input  1  load load_value into counter, go IDLE
load_value  input  TIMER_W  countdown start value
start  input  1  begin/resume counting
pause  input  1  suspend counting
clear  input  1  zero counter, go IDLE, drop expired
tick  output  1  one-cycle pulse per synchronized rising edge of clk_1Hz
remaining  output  TIMER_W  current count
running  output  1  high in RUN
expired  output  1  sticky, high in EXPIRED
expire_pulse  output  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All flops clear on reset_n low; all outputs 0 during and after reset.
- Sync: clk_1Hz passes through SYNC_STAGES flops, then one edge register. tick = sync_out & ~edge_reg, registered.
- Tick latency: SYNC_STAGES+1 cycles after the clk_1Hz rise (+1 cycle of metastability uncertainty). Exactly one tick per rise. No tick on a fall.
- Arm mask: tick is forced 0 for the first SYNC_STAGES+1 cycles after reset release. A clk_1Hz that is high at reset release therefore gives no spurious tick.
- tick is emitted in every state; it is independent of the FSM.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Command priority per cycle: clear > load > start > pause.
- clear (any state): remaining=0, IDLE, expired=0.
- load (any state): remaining=load_value, IDLE, expired=0. Loading while in RUN stops counting.
- start:
  - IDLE or PAUSED with remaining!=0 -> RUN.
  - start with remaining==0 is ignored and the state is unchanged.
  - start in RUN or EXPIRED is ignored.
- pause: RUN -> PAUSED. Ignored in other states.
- RUN with tick and no command: remaining decrements by 1.
  - If remaining was 1, it becomes 0, state goes to EXPIRED, and expire_pulse is asserted in the same registered update as the transition.
- Same-cycle events:
  - tick with pause in RUN: pause wins, no decrement.
  - tick with start from IDLE/PAUSED: no decrement that cycle; the first decrement is on the next tick.
  - tick with load or clear: the command wins, no decrement.
- Ticks in IDLE, PAUSED or EXPIRED do not change remaining.
- EXPIRED: remaining holds 0 and expired=1 until load or clear. No wrap-around below 0, ever.
- running = (state==RUN); expired = (state==EXPIRED). Both are registered.
- Reset mid-count: counter, FSM, synchronizer and arm mask all return to reset values immediately.

Test Plan:
- Reset release with clk_1Hz held high, then 40 cycles with no edges -> tick never asserts; all outputs 0.
- clk_1Hz toggling every 10 cycles -> tick width 1 cycle, 3 cycles after each rise, one per 20 cycles, none on falls.
- load_value=3, load, start -> remaining 3,2,1,0 on successive ticks. At the third tick: running 1->0, expired=1, expire_pulse high for exactly 1 cycle. Further ticks leave remaining=0.
- load 5, start, pause after 2 ticks (remaining=3), apply 3 ticks -> remaining stays 3. Then start -> reaches 0 after 3 more ticks.
- pause and tick in the same cycle at remaining=4 -> remaining stays 4, state PAUSED. start and tick in the same cycle from IDLE -> no decrement.
- start with remaining=0 -> stays IDLE, no expire_pulse. Mid-count, clear and load together -> remaining=0, IDLE. reset_n low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tick_countdown_timer.sv
// Countdown timer clocked by synchronized clk_1Hz rising edges. Latency: tick is SYNC_STAGES+1 cycles after the rise; commands act on the next edge.
// Backpressure: none. Commands are sampled every cycle with priority clear > load > start > pause.
module tick_countdown_timer #(
    parameter int TIMER_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_50MHz,
    input  logic               reset_n,
    input  logic               clk_1Hz,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               start,
    input  logic               pause,
    input  logic               clear,
    output logic               tick,
    output logic [TIMER_W-1:0] remaining,
    output logic               running,
    output logic               expired,
    output logic               expire_pulse
);
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   tick_q, tick_d;
    logic                   armed;

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     remaining_q, remaining_d;
    logic                   running_q, running_d;
    logic                   expired_q, expired_d;
    logic                   expire_pulse_q, expire_pulse_d;

    // Arm mask hides the startup transient of the chain when clk_1Hz is already high.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], clk_1Hz};
        edge_d    = sync_q[SYNC_STAGES-1];
        armed     = (arm_cnt_q == ARM_W'(ARM_CYCLES));
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        tick_d    = armed & sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            arm_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            edge_q    <= edge_d;
            arm_cnt_q <= arm_cnt_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        expire_pulse_d = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else if (load) begin
            state_d     = IDLE;
            remaining_d = load_value;
        end else if (start && (state_q == IDLE || state_q == PAUSED)) begin
            if (remaining_q != '0) begin
                state_d = RUN;
            end
        end else if (pause && state_q == RUN) begin
            state_d = PAUSED;
        end else if (state_q == RUN && tick_q) begin
            // RUN is only entered with a nonzero count, so this never wraps.
            remaining_d = remaining_q - TIMER_W'(1);
            if (remaining_q == TIMER_W'(1)) begin
                state_d        = EXPIRED;
                expire_pulse_d = 1'b1;
            end
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            running_q      <= 1'b0;
            expired_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            running_q      <= running_d;
            expired_q      <= expired_d;
            expire_pulse_q <= expire_pulse_d;
        end
    end

    assign tick         = tick_q;
    assign remaining    = remaining_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign expire_pulse = expire_pulse_q;
endmodule
